// File: rtl/digit_scan_mux.sv
// Time-multiplexing scanner for multi-digit seven-segment displays: steps through
// digits 0..num at a prescaled rate. Optional leading-zero blanking: DIGIT_SCAN_LZB_EN.
module digit_scan_mux #(
  parameter  int NUM_DIGITS     = 8,
  parameter  int DIGIT_W        = 4,
  parameter  int DIV            = 4,
  parameter  int SEL_ACTIVE_LOW = 0,
  localparam int NW             = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [NW-1:0]                 num,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  output logic [DIGIT_W-1:0]            mout,
  output logic [NUM_DIGITS-1:0]         sel_oh,
  output logic                          dp_out,
  output logic                          blank,
  output logic                          frame_done
);

  localparam int                    CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]         CNT_MAX = CW'(DIV - 1);
  localparam logic [NW-1:0]         IDX_MAX = NW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW != 0}};

  // Scan state
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] sel_q, sel_d;
  logic          run_q, run_d;

  // Registered outputs
  logic [DIGIT_W-1:0]    mout_q, mout_d;
  logic [NUM_DIGITS-1:0] sel_oh_q, sel_oh_d;
  logic                  dp_out_q, dp_out_d;
  logic                  blank_q, blank_d;
  logic                  frame_done_q, frame_done_d;

  logic [DIGIT_W-1:0] digit [NUM_DIGITS];
  logic [NW-1:0]      last;
  logic [NW-1:0]      nxt;
  logic               tick;
  logic               suppress;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    assign digit[i] = in[(NUM_DIGITS-i)*DIGIT_W-1 -: DIGIT_W];
  end

  // Only bites when NUM_DIGITS is not a power of two.
  assign last = (num > IDX_MAX) ? IDX_MAX : num;
  assign tick = en && (cnt_q == CNT_MAX);

  // run_q separates "nothing shown yet" from "showing digit 0", so the first
  // tick after reset or re-enable always lands on digit 0.
  assign nxt = (!run_q || (sel_q >= last)) ? '0 : sel_q + NW'(1);

`ifdef DIGIT_SCAN_LZB_EN
  logic [NUM_DIGITS-1:0] lead_zero;

  always_comb begin : p_lead_zero
    logic all_zero;
    all_zero  = 1'b1;
    lead_zero = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      all_zero     = all_zero && (digit[i] == '0) && !dp_in[i];
      lead_zero[i] = all_zero;
    end
  end

  // The last active digit is always shown, even when it is zero.
  assign suppress = (nxt < last) && lead_zero[nxt];
`else
  assign suppress = 1'b0;
`endif

  // NOTE: every signal gets a default at the top of the block, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin : p_next_state
    cnt_d = cnt_q;
    sel_d = sel_q;
    run_d = run_q;
    if (!en) begin
      cnt_d = '0;
      sel_d = '0;
      run_d = 1'b0;
    end else if (tick) begin
      cnt_d = '0;
      sel_d = nxt;
      run_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin : p_outputs
    mout_d       = mout_q;
    sel_oh_d     = sel_oh_q;
    dp_out_d     = dp_out_q;
    blank_d      = blank_q;
    frame_done_d = 1'b0;
    if (!en) begin
      mout_d   = '0;
      sel_oh_d = SEL_OFF;
      dp_out_d = 1'b0;
      blank_d  = 1'b1;
    end else if (tick) begin
      frame_done_d = (nxt == '0);
      if (suppress) begin
        mout_d   = '0;
        sel_oh_d = SEL_OFF;
        dp_out_d = 1'b0;
        blank_d  = 1'b1;
      end else begin
        mout_d   = digit[nxt];
        sel_oh_d = SEL_OFF ^ (NUM_DIGITS'(1) << nxt);
        dp_out_d = dp_in[nxt];
        blank_d  = 1'b0;
      end
    end
  end

  // NOTE: non-blocking assignments here, so every flop samples the values
  // from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      sel_q        <= '0;
      run_q        <= 1'b0;
      mout_q       <= '0;
      sel_oh_q     <= SEL_OFF;
      dp_out_q     <= 1'b0;
      blank_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      run_q        <= run_d;
      mout_q       <= mout_d;
      sel_oh_q     <= sel_oh_d;
      dp_out_q     <= dp_out_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign mout       = mout_q;
  assign sel_oh     = sel_oh_q;
  assign dp_out     = dp_out_q;
  assign blank      = blank_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/digit_scan_mux.md
Name: digit_scan_mux

Overview:
- Parametrised time-multiplexing scanner for multi-digit seven-segment displays.
- Cycles through 1..NUM_DIGITS packed digits at a prescaled scan rate and presents one digit value with its one-hot digit select and decimal point.
- Sits between the display-value registers and the segment decoder / digit drivers.
- Adds async reset, a built-in scan prescaler, a runtime active-digit count, per-digit decimal points and a frame strobe.

Parameters:
- NUM_DIGITS, 8, number of digit positions; must be >= 2.
- DIGIT_W, 4, bits per digit value.
- DIV, 4, clock cycles per digit dwell; must be >= 1.
- SEL_ACTIVE_LOW, 0, 1 = sel_oh active-low (inactive = all ones); 0 = active-high (inactive = all zeros).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable.
- num  in  NW = clog2(NUM_DIGITS)  index of the last active digit; number of digits scanned = num+1.
- in  in  NUM_DIGITS*DIGIT_W  packed digits; digit 0 in the MSBs, digit i = in[(NUM_DIGITS-i)*DIGIT_W-1 -: DIGIT_W].
- dp_in  in  NUM_DIGITS  decimal point per digit; bit i belongs to digit i.
- mout  out  DIGIT_W  value of the currently displayed digit.
- sel_oh  out  NUM_DIGITS  one-hot digit select; bit i drives digit i.
- dp_out  out  1  decimal point of the displayed digit.
- blank  out  1  1 = no digit driven.
- frame_done  out  1  one-cycle pulse when the scan wraps to digit 0.

Behaviour:
- Reset (rst_n=0, async, any time including mid-scan): cnt=0, sel=0, mout=0, sel_oh=inactive, dp_out=0, blank=1, frame_done=0.
- Effective last index: last = min(num, NUM_DIGITS-1). Clamping applies only when NUM_DIGITS is not a power of two.
- Prescaler:
  - cnt counts 0..DIV-1 while en=1.
  - tick = en & (cnt==DIV-1).
  - cnt wraps to 0 on tick.
  - DIV=1 gives a tick every cycle.
- Digit state machine (sel, range 0..NUM_DIGITS-1), evaluated on tick:
  - if sel >= last, next = 0; else next = sel+1.
  - sel <= next.
- Output update, same edge as tick:
  - mout <= digit[next].
  - dp_out <= dp_in[next].
  - sel_oh <= onehot(next), with polarity per SEL_ACTIVE_LOW.
  - blank <= 0.
- Outputs hold between ticks. Changes to in/dp_in become visible only at the next tick.
- frame_done:
  - =1 for exactly the cycle following a tick whose next==0; otherwise 0.
  - With last=0, it pulses on every tick.
- Latency: first digit (digit 0) is shown DIV cycles after en rises following reset.
- num reduced mid-frame with sel > new last: the next tick goes to 0 and pulses frame_done. No out-of-range digit is ever shown.
- num increased mid-frame: the scan continues upward to the new last.
- en=0:
  - Synchronous clear on the next edge to the reset values above (blank=1, sel_oh inactive).
  - On re-enable, scanning restarts at digit 0 after DIV cycles.
- Simultaneous en=0 and tick: en has priority, and the clear occurs.

Optional Feature:
- Macro: DIGIT_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - Digit k is suppressed if k < last, digit[k]==0, dp_in[k]==0, and every digit j<k also satisfies digit[j]==0 and dp_in[j]==0.
  - Suppressed digit: the scan still dwells DIV cycles on it, with sel_oh=inactive, mout=0, dp_out=0, blank=1.
  - Digit last is never suppressed.
  - Evaluation uses the in/dp_in values sampled at the tick.
- Undefined: no suppression; all digits 0..last are displayed.

Test Plan (NUM_DIGITS=8, DIV=4, SEL_ACTIVE_LOW=0 unless stated):
- Assert rst_n=0 mid-scan at sel=5 -> same-cycle: mout=0, sel_oh=0x00, blank=1, frame_done=0. After release with en=1, digit 0 is shown after 4 cycles.
- in=0x12345678, num=2, en=1 -> mout sequence 1,2,3,1,2,3 with each value held 4 cycles. sel_oh sequence 0x01,0x02,0x04. frame_done pulses once per 12 cycles, one cycle after returning to digit 0.
- num=0, in=0xA0000000 -> mout=0xA and sel_oh=0x01 constantly. frame_done pulses every 4 cycles.
- num=7 while scanning; change num to 2 while sel=5 -> next tick shows digit 0 (mout=1 for in=0x12345678) with a frame_done pulse. Digits 6 and 7 are never shown.
- NUM_DIGITS=6, num=7, dp_in=0x20 -> scan covers digits 0..5 only. dp_out=1 only while sel_oh=0x20.
- DIGIT_SCAN_LZB_EN defined, in=0x00050000, num=7, dp_in=0 -> digits 0..2 dwell blank (sel_oh=0, blank=1). Digit 3 shows 5. Digits 4..7 show 0 with blank=0.
